write_resp_order_tracker: RTL and testbench
===========================================

WRITE_RESP_ORDER_TRACKER -- requirements
Module: write_resp_order_tracker

Interface
REQ-001 SHALL have parameter Num_Of_Slaves, default 2: number of interconnect slave ports (S0x) issuing writes.
REQ-002 SHALL have parameter Num_Of_Masters, default 2: number of interconnect master ports (M0x) returning B responses.
REQ-003 SHALL have parameter Depth, default 4: outstanding-write capacity; power of two, >= 2.
REQ-004 SHALL have port ACLK  input  1  single clock for all state.
REQ-005 SHALL have port ARESETN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port AW_Push  input  1  AW handshake completed on an S0x port this cycle.
REQ-007 SHALL have port AW_Src_Port  input  $clog2(Num_Of_Slaves)  index of the issuing S0x port.
REQ-008 SHALL have port AW_Dst_Port  input  $clog2(Num_Of_Masters)  index of the target M0x port.
REQ-009 SHALL have port AW_Allow  output  1  tracker can accept a write; gates upstream awready.
REQ-010 SHALL have port B_Valid  input  1  selected B response valid from the response arbiter.
REQ-011 SHALL have port B_Src_Master  input  $clog2(Num_Of_Masters)  M0x index of the selected response.
REQ-012 SHALL have port B_Pop  input  1  B handshake (bvalid & bready) completed on the S0x side.
REQ-013 SHALL have port Head_Valid  output  1  oldest outstanding entry present.
REQ-014 SHALL have port Exp_Src_Port  output  $clog2(Num_Of_Slaves)  S0x port owed the next response.
REQ-015 SHALL have port Exp_Dst_Port  output  $clog2(Num_Of_Masters)  M0x port expected to answer next.
REQ-016 SHALL have port Outstanding  output  $clog2(Depth+1)  current entry count.
REQ-017 SHALL have port Order_Err, Overflow_Err, Underflow_Err  output  1 each  sticky error flags.

Function
REQ-018 SHALL implement a circular FIFO of Depth entries {Src, Dst}, with write/read pointers $clog2(Depth)+1 bits wide, MSB used as wrap bit.
REQ-019 SHALL define Full = pointers equal except MSB; Empty = pointers equal; Outstanding = wr_ptr - rd_ptr, modulo 2^(ptr width).
REQ-020 SHALL drive AW_Allow = ~Full from registered state only, with no combinational path from B_Pop or AW_Push.
REQ-021 SHALL write {AW_Src_Port, AW_Dst_Port} and increment wr_ptr on a rising ACLK edge when AW_Push=1 and Full=0.
REQ-022 SHALL, when AW_Push=1 and Full=1, drop the push, leave pointers unchanged, and set Overflow_Err, even when B_Pop=1 in the same cycle.
REQ-023 SHALL increment rd_ptr on a rising ACLK edge when B_Pop=1 and Empty=0.
REQ-024 SHALL, when B_Pop=1 and Empty=1, leave pointers unchanged and set Underflow_Err.
REQ-025 SHALL, on a valid push and pop in the same cycle, apply both: Outstanding unchanged, head advances.
REQ-026 SHALL drive Head_Valid = ~Empty and Exp_Src_Port/Exp_Dst_Port = entry at rd_ptr, combinationally from registers; all three are 0 when Empty.
REQ-027 SHALL have a latency of 1 cycle from push to head: push into an empty FIFO at edge N gives Head_Valid=1 after edge N.
REQ-028 SHALL set Order_Err on the edge where B_Valid=1, Head_Valid=1 and B_Src_Master != Exp_Dst_Port.
REQ-029 SHALL set Order_Err on the edge where B_Valid=1 and Head_Valid=0.
REQ-030 SHALL clear error flags only by reset; errors SHALL NOT block normal push/pop.
REQ-031 SHALL wrap pointers naturally at 2*Depth; Full/Empty remain correct across any number of wraps.

Reset
REQ-032 SHALL, while ARESETN=0, asynchronously force wr_ptr=0, rd_ptr=0, all error flags=0, giving Outstanding=0, Head_Valid=0, Exp_*=0, AW_Allow=1.
REQ-033 SHALL discard all outstanding entries on reset assertion mid-operation; entry storage need not be cleared.
REQ-034 SHALL resume push/pop on the first rising ACLK edge after ARESETN deasserts.

Verification
REQ-035 Bench SHALL cover: push {Src=1,Dst=0} -> next cycle Head_Valid=1, Exp_Src_Port=1, Exp_Dst_Port=0, Outstanding=1.
REQ-036 Bench SHALL cover: 4 pushes with Depth=4 -> AW_Allow=0, Outstanding=4; a 5th push -> Overflow_Err=1, Outstanding stays 4.
REQ-037 Bench SHALL cover: full FIFO with simultaneous push and B_Pop -> push dropped, Overflow_Err=1, Outstanding=3.
REQ-038 Bench SHALL cover: head Dst=1 and B_Valid=1 with B_Src_Master=0 -> Order_Err=1 next cycle and held.
REQ-039 Bench SHALL cover: B_Pop on empty -> Underflow_Err=1, Outstanding=0; then 10 push/pop pairs -> wrap-around with correct Exp_* order.
REQ-040 Bench SHALL cover: ARESETN asserted with 3 outstanding -> immediately Outstanding=0, AW_Allow=1, all errors 0.

Source files
------------

// File: rtl/write_resp_order_tracker_if.sv
// Write-response order tracker bus bundle.
// AW issue, B return, head and error status signals.
interface write_resp_order_tracker_if #(
  parameter int Num_Of_Slaves  = 2,
  parameter int Num_Of_Masters = 2,
  parameter int Depth          = 4
);
  localparam int SW = $clog2(Num_Of_Slaves);
  localparam int MW = $clog2(Num_Of_Masters);
  localparam int CW = $clog2(Depth + 1);

  logic          AW_Push;
  logic [SW-1:0] AW_Src_Port;
  logic [MW-1:0] AW_Dst_Port;
  logic          AW_Allow;
  logic          B_Valid;
  logic [MW-1:0] B_Src_Master;
  logic          B_Pop;
  logic          Head_Valid;
  logic [SW-1:0] Exp_Src_Port;
  logic [MW-1:0] Exp_Dst_Port;
  logic [CW-1:0] Outstanding;
  logic          Order_Err;
  logic          Overflow_Err;
  logic          Underflow_Err;

  modport master (
    output AW_Push, AW_Src_Port, AW_Dst_Port,
    output B_Valid, B_Src_Master, B_Pop,
    input  AW_Allow, Head_Valid,
    input  Exp_Src_Port, Exp_Dst_Port, Outstanding,
    input  Order_Err, Overflow_Err, Underflow_Err
  );

  modport slave (
    input  AW_Push, AW_Src_Port, AW_Dst_Port,
    input  B_Valid, B_Src_Master, B_Pop,
    output AW_Allow, Head_Valid,
    output Exp_Src_Port, Exp_Dst_Port, Outstanding,
    output Order_Err, Overflow_Err, Underflow_Err
  );
endinterface

// File: rtl/write_resp_order_tracker.sv
// In-order tracker of outstanding writes: FIFO of {src, dst}
// checked against returning B responses, with sticky errors.
module write_resp_order_tracker #(
  parameter int Num_Of_Slaves  = 2,
  parameter int Num_Of_Masters = 2,
  parameter int Depth          = 4
) (
  input logic ACLK,
  input logic ARESETN,
  write_resp_order_tracker_if.slave bus
);
  localparam int SW = $clog2(Num_Of_Slaves);
  localparam int MW = $clog2(Num_Of_Masters);
  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(Depth + 1);

  logic [SW-1:0] src_mem [Depth];
  logic [MW-1:0] dst_mem [Depth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          order_err_q, order_err_d;
  logic          ovf_err_q, ovf_err_d;
  logic          udf_err_q, udf_err_d;

  logic          full, empty;
  logic          do_push, do_pop;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [SW-1:0] head_src;
  logic [MW-1:0] head_dst;
  logic [PW-1:0] count;

  always_comb begin
    wr_idx   = wr_ptr_q[AW-1:0];
    rd_idx   = rd_ptr_q[AW-1:0];
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head_src = empty ? '0 : src_mem[rd_idx];
    head_dst = empty ? '0 : dst_mem[rd_idx];
    count    = wr_ptr_q - rd_ptr_q;
  end

  always_comb begin
    do_push     = bus.AW_Push & ~full;
    do_pop      = bus.B_Pop & ~empty;
    wr_ptr_d    = wr_ptr_q + PW'(do_push);
    rd_ptr_d    = rd_ptr_q + PW'(do_pop);
    ovf_err_d   = ovf_err_q | (bus.AW_Push & full);
    udf_err_d   = udf_err_q | (bus.B_Pop & empty);
    // A response with nothing owed is as wrong as one from the wrong port.
    order_err_d = order_err_q |
                  (bus.B_Valid &
                   (empty | (bus.B_Src_Master != head_dst)));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      order_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      udf_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      order_err_q <= order_err_d;
      ovf_err_q   <= ovf_err_d;
      udf_err_q   <= udf_err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) begin
      src_mem[wr_idx] <= bus.AW_Src_Port;
      dst_mem[wr_idx] <= bus.AW_Dst_Port;
    end
  end

  assign bus.AW_Allow      = ~full;
  assign bus.Head_Valid    = ~empty;
  assign bus.Exp_Src_Port  = head_src;
  assign bus.Exp_Dst_Port  = head_dst;
  assign bus.Outstanding   = CW'(count);
  assign bus.Order_Err     = order_err_q;
  assign bus.Overflow_Err  = ovf_err_q;
  assign bus.Underflow_Err = udf_err_q;
endmodule

// File: tb/tb_write_resp_order_tracker.sv
// Directed bench for write_resp_order_tracker.
// Hand-computed expectations for Depth=4, 2 slaves, 2 masters.
module tb_write_resp_order_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  write_resp_order_tracker_if #(
    .Num_Of_Slaves(2), .Num_Of_Masters(2), .Depth(4)
  ) bus ();

  write_resp_order_tracker #(
    .Num_Of_Slaves(2), .Num_Of_Masters(2), .Depth(4)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.AW_Push      = 1'b0;
    bus.AW_Src_Port  = '0;
    bus.AW_Dst_Port  = '0;
    bus.B_Valid      = 1'b0;
    bus.B_Src_Master = '0;
    bus.B_Pop        = 1'b0;
  endtask

  // drive one cycle of stimulus at negedge, return #1 past the posedge
  task automatic step(input logic push, input logic src,
                      input logic dst, input logic bval,
                      input logic bsrc, input logic pop);
    @(negedge clk);
    bus.AW_Push      = push;
    bus.AW_Src_Port  = src;
    bus.AW_Dst_Port  = dst;
    bus.B_Valid      = bval;
    bus.B_Src_Master = bsrc;
    bus.B_Pop        = pop;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill4();
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
  endtask

  initial begin
    idle();
    #2;
    chk("rst_out",   32'(bus.Outstanding), 0);
    chk("rst_allow", 32'(bus.AW_Allow), 1);
    chk("rst_head",  32'(bus.Head_Valid), 0);
    chk("rst_errs",  32'({bus.Order_Err, bus.Overflow_Err,
                          bus.Underflow_Err}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single push then pop
    step(1, 1, 0, 0, 0, 0);
    chk("p1_head", 32'(bus.Head_Valid), 1);
    chk("p1_src",  32'(bus.Exp_Src_Port), 1);
    chk("p1_dst",  32'(bus.Exp_Dst_Port), 0);
    chk("p1_out",  32'(bus.Outstanding), 1);
    step(0, 0, 0, 1, 0, 1);
    chk("p1_pop_out",  32'(bus.Outstanding), 0);
    chk("p1_pop_head", 32'(bus.Head_Valid), 0);
    chk("p1_ord",      32'(bus.Order_Err), 0);

    // fill, then overflow
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("f3_allow", 32'(bus.AW_Allow), 1);
    step(1, 1, 1, 0, 0, 0);
    chk("full_allow", 32'(bus.AW_Allow), 0);
    chk("full_out",   32'(bus.Outstanding), 4);
    chk("full_ovf",   32'(bus.Overflow_Err), 0);
    step(1, 1, 1, 0, 0, 0);
    chk("ovf_flag", 32'(bus.Overflow_Err), 1);
    chk("ovf_out",  32'(bus.Outstanding), 4);
    chk("ovf_head", 32'({bus.Exp_Src_Port, bus.Exp_Dst_Port}), 1);

    // full with simultaneous push and pop
    do_reset();
    chk("r2_ovf", 32'(bus.Overflow_Err), 0);
    fill4();
    step(1, 1, 1, 0, 0, 1);
    chk("pp_ovf",   32'(bus.Overflow_Err), 1);
    chk("pp_out",   32'(bus.Outstanding), 3);
    chk("pp_allow", 32'(bus.AW_Allow), 1);
    chk("pp_head",  32'({bus.Exp_Src_Port, bus.Exp_Dst_Port}), 2);

    // ordering: matching response is fine, wrong master flags
    step(0, 0, 0, 1, 0, 1);
    chk("ord_ok",  32'(bus.Order_Err), 0);
    chk("ord_hd",  32'(bus.Exp_Dst_Port), 1);
    step(0, 0, 0, 1, 0, 0);
    chk("ord_bad", 32'(bus.Order_Err), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("ord_held", 32'(bus.Order_Err), 1);
    step(1, 1, 0, 0, 0, 0);
    chk("r3_out", 32'(bus.Outstanding), 3);

    // async reset mid-cycle with 3 outstanding
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out",   32'(bus.Outstanding), 0);
    chk("ar_allow", 32'(bus.AW_Allow), 1);
    chk("ar_head",  32'(bus.Head_Valid), 0);
    chk("ar_exp",   32'({bus.Exp_Src_Port, bus.Exp_Dst_Port}), 0);
    chk("ar_errs",  32'({bus.Order_Err, bus.Overflow_Err,
                         bus.Underflow_Err}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // underflow, then wrap-around with push/pop pairs
    step(0, 0, 0, 0, 0, 1);
    chk("udf_flag", 32'(bus.Underflow_Err), 1);
    chk("udf_out",  32'(bus.Outstanding), 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      logic s, d;
      s = 1'((k + 1) % 2);
      d = 1'(((k + 1) / 2) % 2);
      step(1, s, d, 0, 0, 1);
      chk($sformatf("wrap%0d_exp", k),
          32'({bus.Exp_Src_Port, bus.Exp_Dst_Port}), 32'({s, d}));
      chk($sformatf("wrap%0d_out", k), 32'(bus.Outstanding), 1);
    end
    chk("wrap_ovf", 32'(bus.Overflow_Err), 0);
    chk("wrap_ord", 32'(bus.Order_Err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
